// File: rtl/id_stage_hs.sv
// id_stage_hs: in-order decode stage with valid/ready handshakes, register file,
// load-use interlock and decode-time branch/jump resolution. Optional same-cycle WB bypass: ID_WB_BYPASS_EN.
module id_stage_hs #(
    parameter int unsigned     XLEN   = 32,
    parameter int unsigned     NREGS  = 32,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_ex_load,
    input  logic [4:0]      i_ex_rd,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [XLEN-1:0] o_imm,
    output logic [XLEN-1:0] o_pc,
    output logic [6:0]      o_opcode,
    output logic [2:0]      o_func3,
    output logic [4:0]      o_rd,
    output logic [3:0]      o_alu_ctrl,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc
);
    localparam int unsigned RIDX_W = $clog2(NREGS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_KILL = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            valid_q, valid_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [2:0]      func3_q, func3_d;
    logic [4:0]      rd_q, rd_d;
    logic [3:0]      alu_q, alu_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [4:0]      rs1_idx, rs2_idx;
    logic            uses_rs1, uses_rs2;
    logic            wb_rs1_match, wb_rs2_match;
    logic            lu_hazard, wb_hazard;
    logic            acc, load;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_ctrl;
    logic            br_cond, taken;
    logic [XLEN-1:0] target;

    // Field extraction and source-register usage
    always_comb begin
        opcode   = i_instr[6:0];
        func3    = i_instr[14:12];
        rs1_idx  = i_instr[19:15];
        rs2_idx  = i_instr[24:20];
        uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
        uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
        wb_rs1_match = i_wb_we && (i_wb_rd == rs1_idx) && (rs1_idx != 5'd0);
        wb_rs2_match = i_wb_we && (i_wb_rd == rs2_idx) && (rs2_idx != 5'd0);
    end

    // Register file read; out-of-range indices (RV32E) read as zero
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if ((rs1_idx != 5'd0) && (32'(rs1_idx) < NREGS)) begin
            rs1_val = regs_q[rs1_idx[RIDX_W-1:0]];
`ifdef ID_WB_BYPASS_EN
            if (wb_rs1_match) rs1_val = i_wb_data;
`endif
        end
        if ((rs2_idx != 5'd0) && (32'(rs2_idx) < NREGS)) begin
            rs2_val = regs_q[rs2_idx[RIDX_W-1:0]];
`ifdef ID_WB_BYPASS_EN
            if (wb_rs2_match) rs2_val = i_wb_data;
`endif
        end
    end

    // Immediate generation and ALU control
    always_comb begin
        imm      = '0;
        alu_ctrl = 4'd0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: imm = XLEN'($signed(i_instr[31:20]));
            OP_STORE:  imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
            OP_BRANCH: imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                            i_instr[11:8], 1'b0}));
            OP_LUI, OP_AUIPC: imm = XLEN'($signed({i_instr[31:12], 12'b0}));
            OP_JAL:    imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                            i_instr[30:21], 1'b0}));
            default:   imm = '0;
        endcase
        case (opcode)
            OP_REG:  alu_ctrl = {i_instr[30], func3};
            OP_IMM:  alu_ctrl = (func3 == 3'b101) ? {i_instr[30], func3} : {1'b0, func3};
            default: alu_ctrl = 4'd0;
        endcase
    end

    // Branch/jump resolution on the operands being decoded
    always_comb begin
        br_cond = 1'b0;
        case (func3)
            3'b000:  br_cond = (rs1_val == rs2_val);
            3'b001:  br_cond = (rs1_val != rs2_val);
            3'b100:  br_cond = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_cond = (rs1_val <  rs2_val);
            3'b111:  br_cond = (rs1_val >= rs2_val);
            default: br_cond = 1'b0;
        endcase
        taken  = 1'b0;
        target = i_pc + imm;
        case (opcode)
            OP_BRANCH: taken = br_cond;
            OP_JAL:    taken = 1'b1;
            OP_JALR: begin
                taken  = 1'b1;
                target = (rs1_val + imm) & ~XLEN'(1);
            end
            default:   taken = 1'b0;
        endcase
    end

    // Handshake and interlocks; the KILL cycle swallows whatever fetch presents
    always_comb begin
        lu_hazard = i_ex_load && (i_ex_rd != 5'd0) &&
                    ((uses_rs1 && (i_ex_rd == rs1_idx)) || (uses_rs2 && (i_ex_rd == rs2_idx)));
`ifdef ID_WB_BYPASS_EN
        wb_hazard = 1'b0;
`else
        wb_hazard = (uses_rs1 && wb_rs1_match) || (uses_rs2 && wb_rs2_match);
`endif
        o_ready = (state_q == ST_KILL) || ((!valid_q || i_ready) && !lu_hazard && !wb_hazard);
        acc     = i_valid && o_ready;
        load    = acc && (state_q == ST_RUN);
    end

    // Register file write port
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
        if (i_wb_we && (i_wb_rd != 5'd0) && (32'(i_wb_rd) < NREGS))
            regs_d[i_wb_rd[RIDX_W-1:0]] = i_wb_data;
    end

    // Output register and RUN/KILL sequencing
    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        imm_d         = imm_q;
        pc_d          = pc_q;
        opcode_d      = opcode_q;
        func3_d       = func3_q;
        rd_d          = rd_q;
        alu_d         = alu_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        if (load) begin
            valid_d  = 1'b1;
            rs1_d    = rs1_val;
            rs2_d    = rs2_val;
            imm_d    = imm;
            pc_d     = i_pc;
            opcode_d = opcode;
            func3_d  = func3;
            rd_d     = i_instr[11:7];
            alu_d    = alu_ctrl;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        case (state_q)
            ST_RUN: begin
                if (load && taken) begin
                    state_d       = ST_KILL;
                    redirect_d    = 1'b1;
                    redirect_pc_d = target;
                end
            end
            ST_KILL: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            valid_q       <= 1'b0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            imm_q         <= '0;
            pc_q          <= RST_PC;
            opcode_q      <= 7'd0;
            func3_q       <= 3'd0;
            rd_q          <= 5'd0;
            alu_q         <= 4'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= RST_PC;
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            imm_q         <= imm_d;
            pc_q          <= pc_d;
            opcode_q      <= opcode_d;
            func3_q       <= func3_d;
            rd_q          <= rd_d;
            alu_q         <= alu_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign o_valid       = valid_q;
    assign o_rs1_data    = rs1_q;
    assign o_rs2_data    = rs2_q;
    assign o_imm         = imm_q;
    assign o_pc          = pc_q;
    assign o_opcode      = opcode_q;
    assign o_func3       = func3_q;
    assign o_rd          = rd_q;
    assign o_alu_ctrl    = alu_q;
    assign o_redirect    = redirect_q;
    assign o_redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_id_stage_hs.sv
// Bench for id_stage_hs: directed scenarios plus randomized traffic against a
// transaction-level decode model (RV32I instance and an RV32E instance).
module tb_id_stage_hs;
    localparam int unsigned XLEN   = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0040;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_ready, i_wb_we, i_ex_load;
    logic [31:0] i_instr, i_pc, i_wb_data;
    logic [4:0]  i_wb_rd, i_ex_rd;

    logic        o_ready, o_valid, o_redirect;
    logic [31:0] o_rs1_data, o_rs2_data, o_imm, o_pc, o_redirect_pc;
    logic [6:0]  o_opcode;
    logic [2:0]  o_func3;
    logic [4:0]  o_rd;
    logic [3:0]  o_alu_ctrl;

    logic        e_ready, e_valid, e_redirect;
    logic [31:0] e_rs1_data, e_rs2_data, e_imm, e_pc, e_redirect_pc;
    logic [6:0]  e_opcode;
    logic [2:0]  e_func3;
    logic [4:0]  e_rd;
    logic [3:0]  e_alu_ctrl;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    id_stage_hs #(.XLEN(XLEN), .NREGS(32), .RST_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd),
        .i_wb_data(i_wb_data), .i_ex_load(i_ex_load), .i_ex_rd(i_ex_rd),
        .o_valid(o_valid), .i_ready(i_ready), .o_rs1_data(o_rs1_data),
        .o_rs2_data(o_rs2_data), .o_imm(o_imm), .o_pc(o_pc), .o_opcode(o_opcode),
        .o_func3(o_func3), .o_rd(o_rd), .o_alu_ctrl(o_alu_ctrl),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc)
    );

    id_stage_hs #(.XLEN(XLEN), .NREGS(16), .RST_PC(RST_PC)) dut_e (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(e_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd),
        .i_wb_data(i_wb_data), .i_ex_load(i_ex_load), .i_ex_rd(i_ex_rd),
        .o_valid(e_valid), .i_ready(i_ready), .o_rs1_data(e_rs1_data),
        .o_rs2_data(e_rs2_data), .o_imm(e_imm), .o_pc(e_pc), .o_opcode(e_opcode),
        .o_func3(e_func3), .o_rd(e_rd), .o_alu_ctrl(e_alu_ctrl),
        .o_redirect(e_redirect), .o_redirect_pc(e_redirect_pc)
    );

    typedef struct {
        logic [31:0] rs1, rs2, imm, pc, target;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        taken;
    } dec_t;

    // Architectural model state
    logic [31:0] m_regs [32];
    logic        m_valid, m_kill, m_redir;
    logic [31:0] m_rpc;
    dec_t        m_b;

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_REG};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    function automatic logic uses1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses2(input logic [6:0] op);
        return (op == OP_REG || op == OP_STORE || op == OP_BRANCH);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (i_wb_we && i_wb_rd == r) return i_wb_data;
`endif
        return m_regs[r];
    endfunction

    function automatic logic m_ready();
        logic [6:0] op;
        logic [4:0] r1, r2;
        logic lu, wb;
        if (m_kill) return 1'b1;
        op = i_instr[6:0];
        r1 = i_instr[19:15];
        r2 = i_instr[24:20];
        lu = i_ex_load && i_ex_rd != 5'd0 &&
             ((uses1(op) && i_ex_rd == r1) || (uses2(op) && i_ex_rd == r2));
`ifdef ID_WB_BYPASS_EN
        wb = 1'b0;
`else
        wb = i_wb_we && i_wb_rd != 5'd0 &&
             ((uses1(op) && i_wb_rd == r1) || (uses2(op) && i_wb_rd == r2));
`endif
        return (!m_valid || i_ready) && !lu && !wb;
    endfunction

    // Decode by instruction-set rules using signed shifts rather than bit packing
    function automatic dec_t decode(input logic [31:0] w, input logic [31:0] pc);
        dec_t d;
        logic signed [31:0] s;
        s = $signed(w);
        d.op = w[6:0];
        d.f3 = w[14:12];
        d.rd = w[11:7];
        d.pc = pc;
        d.rs1 = m_read(w[19:15]);
        d.rs2 = m_read(w[24:20]);
        case (d.op)
            OP_IMM, OP_LOAD, OP_JALR: d.imm = 32'(s >>> 20);
            OP_STORE:  d.imm = 32'((s >>> 25) <<< 5) | 32'(w[11:7]);
            OP_BRANCH: d.imm = 32'((s >>> 31) <<< 12) | (32'(w[7]) << 11) |
                               (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            OP_LUI, OP_AUIPC: d.imm = w & 32'hFFFF_F000;
            OP_JAL:    d.imm = 32'((s >>> 31) <<< 20) | (32'(w[19:12]) << 12) |
                               (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            default:   d.imm = 32'd0;
        endcase
        if (d.op == OP_REG || (d.op == OP_IMM && d.f3 == 3'd5)) d.alu = {w[30], d.f3};
        else if (d.op == OP_IMM) d.alu = {1'b0, d.f3};
        else d.alu = 4'd0;
        d.taken  = 1'b0;
        d.target = pc + d.imm;
        if (d.op == OP_BRANCH) begin
            case (d.f3)
                3'd0: d.taken = (d.rs1 == d.rs2);
                3'd1: d.taken = (d.rs1 != d.rs2);
                3'd4: d.taken = ($signed(d.rs1) < $signed(d.rs2));
                3'd5: d.taken = !($signed(d.rs1) < $signed(d.rs2));
                3'd6: d.taken = (d.rs1 < d.rs2);
                3'd7: d.taken = !(d.rs1 < d.rs2);
                default: d.taken = 1'b0;
            endcase
        end else if (d.op == OP_JAL) begin
            d.taken = 1'b1;
        end else if (d.op == OP_JALR) begin
            d.taken  = 1'b1;
            d.target = (d.rs1 + d.imm) & 32'hFFFF_FFFE;
        end
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid = 1'b0;
        m_kill  = 1'b0;
        m_redir = 1'b0;
        m_rpc   = RST_PC;
    endtask

    task automatic idle();
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_wb_we   = 1'b0;
        i_wb_rd   = 5'd0;
        i_wb_data = 32'd0;
        i_ex_load = 1'b0;
        i_ex_rd   = 5'd0;
        i_instr   = 32'h0000_0013;
        i_pc      = 32'd0;
    endtask

    // One clock: advance the model on the current inputs, then settle past the edge
    task automatic step();
        logic rdy;
        dec_t d;
        rdy = m_ready();
        d   = decode(i_instr, i_pc);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_kill) begin
                m_kill  = 1'b0;
                m_redir = 1'b0;
                if (m_valid && i_ready) m_valid = 1'b0;
            end else if (i_valid && rdy) begin
                m_valid = 1'b1;
                m_b     = d;
                m_redir = d.taken;
                if (d.taken) begin
                    m_rpc  = d.target;
                    m_kill = 1'b1;
                end
            end else begin
                m_redir = 1'b0;
                if (m_valid && i_ready) m_valid = 1'b0;
            end
            if (i_wb_we && i_wb_rd != 5'd0) m_regs[i_wb_rd] = i_wb_data;
        end
        #1;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
        i_valid = 1'b0; i_wb_we = 1'b1; i_wb_rd = r; i_wb_data = v;
        step();
        i_wb_we = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        n_total++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%0h exp=0", o_valid); end
        n_total++; if (o_redirect !== 1'b0) begin n_bad++; $display("FAIL rst_redirect got=%0h exp=0", o_redirect); end
        n_total++; if (o_pc !== RST_PC) begin n_bad++; $display("FAIL rst_pc got=%0h exp=%0h", o_pc, RST_PC); end
        n_total++; if (o_redirect_pc !== RST_PC) begin n_bad++; $display("FAIL rst_rpc got=%0h exp=%0h", o_redirect_pc, RST_PC); end
        n_total++; if ({o_rd, o_opcode, o_func3, o_alu_ctrl} !== 19'd0) begin n_bad++; $display("FAIL rst_ctl got=%0h exp=0", {o_rd, o_opcode, o_func3, o_alu_ctrl}); end
        n_total++; if ({o_rs1_data, o_rs2_data, o_imm} !== 96'd0) begin n_bad++; $display("FAIL rst_data got=%0h exp=0", {o_rs1_data, o_rs2_data, o_imm}); end
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        wb_write(5'd5, 32'h10);
        i_instr = enc_i(OP_IMM, 5'd6, 3'd0, 5'd5, 12'd3); i_pc = 32'h10; i_valid = 1'b1;
        #1;
        n_total++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL addi_ready got=%0h exp=1", o_ready); end
        step();
        i_valid = 1'b0;
        n_total++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL addi_valid got=%0h exp=1", o_valid); end
        n_total++; if (o_rs1_data !== 32'h10) begin n_bad++; $display("FAIL addi_rs1 got=%0h exp=10", o_rs1_data); end
        n_total++; if (o_imm !== 32'd3) begin n_bad++; $display("FAIL addi_imm got=%0h exp=3", o_imm); end
        n_total++; if (o_rd !== 5'd6) begin n_bad++; $display("FAIL addi_rd got=%0d exp=6", o_rd); end
        n_total++; if (o_opcode !== OP_IMM || o_pc !== 32'h10) begin n_bad++; $display("FAIL addi_oppc got=%0h/%0h exp=13/10", o_opcode, o_pc); end
    endtask

    task automatic test_load_use();
        i_ex_load = 1'b1; i_ex_rd = 5'd7;
        i_instr = enc_r(7'd0, 5'd1, 5'd7, 3'd0, 5'd8); i_pc = 32'h20; i_valid = 1'b1;
        #1;
        n_total++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL lu_stall got=%0h exp=0", o_ready); end
        step();
        n_total++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble got=%0h exp=0", o_valid); end
        i_ex_load = 1'b0;
        #1;
        n_total++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL lu_release got=%0h exp=1", o_ready); end
        step();
        n_total++; if (o_valid !== 1'b1 || o_rd !== 5'd8 || o_pc !== 32'h20) begin n_bad++; $display("FAIL lu_accept got=%0h/%0d/%0h exp=1/8/20", o_valid, o_rd, o_pc); end
        i_ex_load = 1'b1; i_ex_rd = 5'd8;
        i_instr = {20'h12345, 5'd8, OP_LUI}; i_pc = 32'h24;
        #1;
        n_total++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL lui_nostall got=%0h exp=1", o_ready); end
        step();
        n_total++; if (o_imm !== 32'h1234_5000 || o_valid !== 1'b1) begin n_bad++; $display("FAIL lui_imm got=%0h exp=12345000", o_imm); end
        i_ex_load = 1'b0; i_valid = 1'b0;
    endtask

    task automatic test_branch();
        wb_write(5'd1, 32'h55);
        wb_write(5'd2, 32'h55);
        i_instr = enc_b(3'd0, 5'd1, 5'd2, 13'h020); i_pc = 32'h100; i_valid = 1'b1;
        step();
        n_total++; if (o_redirect !== 1'b1) begin n_bad++; $display("FAIL beq_redirect got=%0h exp=1", o_redirect); end
        n_total++; if (o_redirect_pc !== 32'h120) begin n_bad++; $display("FAIL beq_target got=%0h exp=120", o_redirect_pc); end
        n_total++; if (o_valid !== 1'b1 || o_pc !== 32'h100) begin n_bad++; $display("FAIL beq_pass got=%0h/%0h exp=1/100", o_valid, o_pc); end
        i_instr = enc_i(OP_IMM, 5'd9, 3'd0, 5'd0, 12'd1); i_pc = 32'h104;
        #1;
        n_total++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL kill_ready got=%0h exp=1", o_ready); end
        step();
        n_total++; if (o_redirect !== 1'b0 || o_valid !== 1'b0) begin n_bad++; $display("FAIL kill_drop got=%0h/%0h exp=0/0", o_redirect, o_valid); end
        i_instr = enc_i(OP_IMM, 5'd10, 3'd0, 5'd0, 12'd7); i_pc = 32'h120;
        step();
        n_total++; if (o_valid !== 1'b1 || o_pc !== 32'h120 || o_rd !== 5'd10) begin n_bad++; $display("FAIL beq_next got=%0h/%0h/%0d exp=1/120/10", o_valid, o_pc, o_rd); end
        i_instr = enc_b(3'd1, 5'd1, 5'd2, 13'h020); i_pc = 32'h130;
        step();
        n_total++; if (o_redirect !== 1'b0 || o_valid !== 1'b1) begin n_bad++; $display("FAIL bne_nt got=%0h/%0h exp=0/1", o_redirect, o_valid); end
        i_instr = enc_i(OP_IMM, 5'd11, 3'd0, 5'd0, 12'd2); i_pc = 32'h134;
        step();
        n_total++; if (o_valid !== 1'b1 || o_pc !== 32'h134) begin n_bad++; $display("FAIL bne_next got=%0h/%0h exp=1/134", o_valid, o_pc); end
        i_valid = 1'b0;
    endtask

    task automatic test_jalr();
        wb_write(5'd3, 32'h200);
        i_instr = enc_i(OP_JALR, 5'd1, 3'd0, 5'd3, 12'd5); i_pc = 32'h300; i_valid = 1'b1;
        step();
        n_total++; if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h204) begin n_bad++; $display("FAIL jalr_target got=%0h/%0h exp=1/204", o_redirect, o_redirect_pc); end
        i_valid = 1'b0;
        step();
        n_total++; if (o_redirect !== 1'b0) begin n_bad++; $display("FAIL jalr_pulse got=%0h exp=0", o_redirect); end
    endtask

    task automatic test_wb_same_cycle();
        i_wb_we = 1'b1; i_wb_rd = 5'd9; i_wb_data = 32'hAB;
        i_instr = enc_i(OP_IMM, 5'd11, 3'd0, 5'd9, 12'd0); i_pc = 32'h400; i_valid = 1'b1;
        #1;
`ifdef ID_WB_BYPASS_EN
        n_total++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL wbby_ready got=%0h exp=1", o_ready); end
        step();
        i_wb_we = 1'b0;
`else
        n_total++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL wbhz_stall got=%0h exp=0", o_ready); end
        step();
        i_wb_we = 1'b0;
        #1;
        n_total++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL wbhz_release got=%0h exp=1", o_ready); end
        step();
`endif
        n_total++; if (o_valid !== 1'b1 || o_rs1_data !== 32'hAB) begin n_bad++; $display("FAIL wb_rs1 got=%0h/%0h exp=1/ab", o_valid, o_rs1_data); end
        i_valid = 1'b0;
    endtask

    task automatic test_hold();
        i_instr = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd12); i_pc = 32'h500; i_valid = 1'b1;
        step();
        i_ready = 1'b0;
        i_instr = enc_i(OP_IMM, 5'd13, 3'd0, 5'd1, 12'd1); i_pc = 32'h504;
        for (int k = 0; k < 3; k++) begin
            i_ex_load = (k == 1); i_ex_rd = 5'd1;
            #1;
            n_total++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready k=%0d got=%0h exp=0", k, o_ready); end
            step();
            n_total++;
            if (o_valid !== 1'b1 || o_pc !== 32'h500 || o_rd !== 5'd12 || o_rs1_data !== 32'h55 || o_alu_ctrl !== 4'b1000) begin
                n_bad++; $display("FAIL hold_stable k=%0d got=%0h/%0h/%0d/%0h/%0h exp=1/500/12/55/8", k, o_valid, o_pc, o_rd, o_rs1_data, o_alu_ctrl);
            end
        end
        i_ready = 1'b1; i_ex_load = 1'b0;
        step();
        n_total++; if (o_pc !== 32'h504 || o_rd !== 5'd13) begin n_bad++; $display("FAIL hold_next got=%0h/%0d exp=504/13", o_pc, o_rd); end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_nregs16();
        wb_write(5'd20, 32'h77);
        i_instr = enc_i(OP_IMM, 5'd21, 3'd0, 5'd20, 12'd0); i_pc = 32'h600; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        n_total++; if (e_valid !== 1'b1 || e_rs1_data !== 32'd0) begin n_bad++; $display("FAIL rv32e_x20 got=%0h/%0h exp=1/0", e_valid, e_rs1_data); end
        n_total++; if (o_rs1_data !== 32'h77) begin n_bad++; $display("FAIL rv32i_x20 got=%0h exp=77", o_rs1_data); end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0] op;
        w = $urandom;
        case ($urandom_range(0, 8))
            0: op = OP_REG;    1: op = OP_IMM;   2: op = OP_LOAD;
            3: op = OP_STORE;  4: op = OP_BRANCH; 5: op = OP_LUI;
            6: op = OP_AUIPC;  7: op = OP_JAL;   default: op = OP_JALR;
        endcase
        w[6:0]   = op;
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            i_valid   = 1'($urandom_range(0, 1));
            i_ready   = ($urandom_range(0, 3) != 0);
            i_wb_we   = 1'($urandom_range(0, 1));
            i_wb_rd   = 5'($urandom_range(0, 7));
            i_wb_data = $urandom;
            i_ex_load = ($urandom_range(0, 3) == 0);
            i_ex_rd   = 5'($urandom_range(0, 7));
            i_instr   = rand_instr();
            i_pc      = $urandom & 32'hFFFF_FFFC;
            #1;
            n_total++; if (o_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_ready c=%0d got=%0h exp=%0h", c, o_ready, m_ready()); end
            step();
            n_total++; if (o_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid c=%0d got=%0h exp=%0h", c, o_valid, m_valid); end
            n_total++; if (o_redirect !== m_redir || o_redirect_pc !== m_rpc) begin n_bad++; $display("FAIL rnd_redir c=%0d got=%0h/%0h exp=%0h/%0h", c, o_redirect, o_redirect_pc, m_redir, m_rpc); end
            if (m_valid) begin
                n_total++;
                if (o_rs1_data !== m_b.rs1 || o_rs2_data !== m_b.rs2 || o_imm !== m_b.imm || o_pc !== m_b.pc) begin
                    n_bad++; $display("FAIL rnd_data c=%0d got=%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h", c, o_rs1_data, o_rs2_data, o_imm, o_pc, m_b.rs1, m_b.rs2, m_b.imm, m_b.pc);
                end
                n_total++;
                if (o_opcode !== m_b.op || o_func3 !== m_b.f3 || o_rd !== m_b.rd || o_alu_ctrl !== m_b.alu) begin
                    n_bad++; $display("FAIL rnd_ctl c=%0d got=%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h", c, o_opcode, o_func3, o_rd, o_alu_ctrl, m_b.op, m_b.f3, m_b.rd, m_b.alu);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        step();
        step();
        i_instr = enc_j(5'd1, 21'h10); i_pc = 32'h700; i_valid = 1'b1;
        step();
        n_total++; if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h710) begin n_bad++; $display("FAIL jal_target got=%0h/%0h exp=1/710", o_redirect, o_redirect_pc); end
        i_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_total++; if (o_valid !== 1'b0 || o_redirect !== 1'b0 || o_redirect_pc !== RST_PC) begin n_bad++; $display("FAIL midrst_state got=%0h/%0h/%0h exp=0/0/%0h", o_valid, o_redirect, o_redirect_pc, RST_PC); end
        i_instr = enc_i(OP_IMM, 5'd6, 3'd0, 5'd5, 12'd0); i_pc = 32'h800; i_valid = 1'b1;
        step();
        n_total++; if (o_valid !== 1'b1 || o_rs1_data !== 32'd0 || o_pc !== 32'h800) begin n_bad++; $display("FAIL midrst_rf got=%0h/%0h/%0h exp=1/0/800", o_valid, o_rs1_data, o_pc); end
        i_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        idle();
        rst_n = 1'b0;
        test_reset();
        test_addi();
        test_load_use();
        test_branch();
        test_jalr();
        test_wb_same_cycle();
        test_hold();
        test_nregs16();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
